// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the RV32I multicycle main control FSM.
package ctrl_pkg;

   typedef enum logic [2:0] {
      RESET_S,
      FETCH,
      DECODE,
      EXEC,
      MEM,
      WB,
      TRAP
   } state_e;

   localparam int unsigned ALUOP_W     = 3;
   localparam int unsigned ALU_INSTR_W = 4;

   localparam logic [ALUOP_W-1:0] ALUOP_R      = 3'd0;
   localparam logic [ALUOP_W-1:0] ALUOP_BRANCH = 3'd1;
   localparam logic [ALUOP_W-1:0] ALUOP_LS     = 3'd2;
   localparam logic [ALUOP_W-1:0] ALUOP_I      = 3'd3;
   localparam logic [ALUOP_W-1:0] ALUOP_AUIPC  = 3'd4;
   localparam logic [ALUOP_W-1:0] ALUOP_LUI    = 3'd5;
   localparam logic [ALUOP_W-1:0] ALUOP_JAL    = 3'd6;
   localparam logic [ALUOP_W-1:0] ALUOP_JALR   = 3'd7;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   // Shift-right funct3: only I-type encoding where funct7[5] selects SRA vs SRL
   localparam logic [2:0] FUNCT3_SR = 3'b101;

   localparam logic [1:0] PC_SRC_PC4    = 2'b00;
   localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
   localparam logic [1:0] PC_SRC_ALU    = 2'b10;

   localparam logic [1:0] WB_SEL_ALU = 2'b00;
   localparam logic [1:0] WB_SEL_MEM = 2'b01;
   localparam logic [1:0] WB_SEL_PC4 = 2'b10;

   typedef struct packed {
      logic [ALUOP_W-1:0]     alu_op;
      logic [ALU_INSTR_W-1:0] alu_instr;
      logic                   is_load;
      logic                   is_store;
      logic                   is_branch;
      logic                   legal;
   } dec_t;

endpackage

// File: rtl/opcode_class_dec.sv
// Combinational opcode classifier: ALUOp class, ALU-control field and memory/branch flags.
module opcode_class_dec
   import ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   output dec_t       dec
);

   always_comb begin
      dec           = '0;
      dec.legal     = 1'b1;
      dec.alu_instr = {1'b0, funct3};
      case (opcode)
         OPC_OP: begin
            dec.alu_op       = ALUOP_R;
            dec.alu_instr[3] = funct7_5;
         end
         OPC_BRANCH: begin
            dec.alu_op    = ALUOP_BRANCH;
            dec.is_branch = 1'b1;
         end
         OPC_LOAD: begin
            dec.alu_op  = ALUOP_LS;
            dec.is_load = 1'b1;
         end
         OPC_STORE: begin
            dec.alu_op   = ALUOP_LS;
            dec.is_store = 1'b1;
         end
         OPC_OPIMM: begin
            // imm[10] is a real immediate bit except for shift-right
            dec.alu_op       = ALUOP_I;
            dec.alu_instr[3] = (funct3 == FUNCT3_SR) & funct7_5;
         end
         OPC_AUIPC: dec.alu_op = ALUOP_AUIPC;
         OPC_LUI:   dec.alu_op = ALUOP_LUI;
         OPC_JAL:   dec.alu_op = ALUOP_JAL;
         OPC_JALR:  dec.alu_op = ALUOP_JALR;
         default: begin
            dec.legal     = 1'b0;
            dec.alu_instr = '0;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// RV32I multicycle main control: fetch over req/ready, decode, and per-state datapath strobes.
module multicycle_control
   import ctrl_pkg::*;
#(
   parameter int unsigned RESET_PC_HOLD = 0
) (
   input  logic       CLK,
   input  logic       RST_n,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       branch_taken,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       ir_we,
   output logic       pc_we,
   output logic [1:0] pc_src,
   output logic       alu_src_a,
   output logic       alu_src_b,
   output logic [2:0] alu_op,
   output logic [3:0] alu_instr,
   output logic       reg_we,
   output logic [1:0] wb_sel,
   output logic       illegal
);

   localparam int unsigned HOLD_W = (RESET_PC_HOLD > 0) ? $clog2(RESET_PC_HOLD + 1) : 1;

   state_e                 state_q, state_d;
   logic [HOLD_W-1:0]      hold_q, hold_d;
   logic [ALUOP_W-1:0]     alu_op_q, alu_op_d;
   logic [ALU_INSTR_W-1:0] alu_instr_q, alu_instr_d;
   logic                   is_load_q, is_load_d;
   logic                   is_store_q, is_store_d;
   logic                   is_branch_q, is_branch_d;
   dec_t                   dec;

   opcode_class_dec u_dec (
      .opcode   (opcode),
      .funct3   (funct3),
      .funct7_5 (funct7_5),
      .dec      (dec)
   );

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state_q     <= RESET_S;
         hold_q      <= '0;
         alu_op_q    <= '0;
         alu_instr_q <= '0;
         is_load_q   <= 1'b0;
         is_store_q  <= 1'b0;
         is_branch_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         alu_op_q    <= alu_op_d;
         alu_instr_q <= alu_instr_d;
         is_load_q   <= is_load_d;
         is_store_q  <= is_store_d;
         is_branch_q <= is_branch_d;
      end
   end

   // Next state and strobes; strobes decode only state_q and the fields latched in DECODE
   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      alu_op_d    = alu_op_q;
      alu_instr_d = alu_instr_q;
      is_load_d   = is_load_q;
      is_store_d  = is_store_q;
      is_branch_d = is_branch_q;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      pc_src      = PC_SRC_PC4;
      alu_src_a   = 1'b0;
      alu_src_b   = 1'b0;
      reg_we      = 1'b0;
      wb_sel      = WB_SEL_ALU;
      illegal     = 1'b0;
      alu_op      = alu_op_q;
      alu_instr   = alu_instr_q;

      case (state_q)
         RESET_S: begin
            if (hold_q == HOLD_W'(RESET_PC_HOLD)) state_d = FETCH;
            else                                  hold_d  = hold_q + HOLD_W'(1);
         end
         FETCH: begin
            mem_req = 1'b1;
            ir_we   = mem_ready;
            pc_we   = mem_ready;
            if (mem_ready) state_d = DECODE;
         end
         DECODE: begin
            alu_op_d    = dec.alu_op;
            alu_instr_d = dec.alu_instr;
            is_load_d   = dec.is_load;
            is_store_d  = dec.is_store;
            is_branch_d = dec.is_branch;
            state_d     = dec.legal ? EXEC : TRAP;
         end
         EXEC: begin
            state_d = WB;
            if (is_branch_q) begin
               pc_we   = branch_taken;
               pc_src  = PC_SRC_BRANCH;
               state_d = FETCH;
            end else begin
               case (alu_op_q)
                  ALUOP_LS: begin
                     alu_src_b = 1'b1;
                     state_d   = MEM;
                  end
                  ALUOP_I, ALUOP_LUI: alu_src_b = 1'b1;
                  ALUOP_AUIPC: begin
                     alu_src_a = 1'b1;
                     alu_src_b = 1'b1;
                  end
                  ALUOP_JAL: begin
                     alu_src_a = 1'b1;
                     alu_src_b = 1'b1;
                     pc_we     = 1'b1;
                     pc_src    = PC_SRC_ALU;
                  end
                  ALUOP_JALR: begin
                     alu_src_b = 1'b1;
                     pc_we     = 1'b1;
                     pc_src    = PC_SRC_ALU;
                  end
                  default: ;
               endcase
            end
         end
         MEM: begin
            mem_req = 1'b1;
            mem_we  = is_store_q;
            if (mem_ready) state_d = is_store_q ? FETCH : WB;
         end
         WB: begin
            reg_we = 1'b1;
            if (is_load_q)
               wb_sel = WB_SEL_MEM;
            else if (alu_op_q == ALUOP_JAL || alu_op_q == ALUOP_JALR)
               wb_sel = WB_SEL_PC4;
            state_d = FETCH;
         end
         TRAP: illegal = 1'b1;
         default: state_d = RESET_S;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed instruction table, random instruction stream, reset/trap corners.
module tb_multicycle_control;

   logic       CLK = 1'b0;
   logic       RST_n;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7_5, branch_taken, mem_ready;
   logic       mem_req, mem_we, ir_we, pc_we, alu_src_a, alu_src_b, reg_we, illegal;
   logic [1:0] pc_src, wb_sel;
   logic [2:0] alu_op;
   logic [3:0] alu_instr;

   always #5 CLK = ~CLK;

   multicycle_control dut (
      .CLK(CLK), .RST_n(RST_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
      .branch_taken(branch_taken), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
      .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .alu_instr(alu_instr), .reg_we(reg_we), .wb_sel(wb_sel), .illegal(illegal)
   );

   typedef struct packed {
      logic       mem_req, mem_we, ir_we, pc_we;
      logic [1:0] pc_src;
      logic       a, b;
      logic [2:0] aop;
      logic [3:0] ains;
      logic       reg_we;
      logic [1:0] wb_sel;
      logic       illegal;
   } out_t;

   typedef struct {
      logic mr;
      logic bt;
      logic chk_alu;
      out_t exp;
   } cyc_t;

   typedef struct {
      logic [31:0] instr;
      int fw, mw;
      logic taken;
      int nreq, lat, rw, wbs, pcw, stc;
      logic [6:0] alu;
   } tv_t;

   localparam int K_R = 0, K_BR = 1, K_LD = 2, K_ST = 3, K_I = 4;
   localparam int K_AUI = 5, K_LUI = 6, K_JAL = 7, K_JALR = 8, K_ILL = 9;

   cyc_t mq[$];
   int   checks = 0;
   int   failures = 0;

   function automatic out_t sample();
      out_t o;
      o.mem_req = mem_req;   o.mem_we = mem_we;   o.ir_we = ir_we;   o.pc_we = pc_we;
      o.pc_src  = pc_src;    o.a = alu_src_a;     o.b = alu_src_b;   o.aop = alu_op;
      o.ains    = alu_instr; o.reg_we = reg_we;   o.wb_sel = wb_sel; o.illegal = illegal;
      return o;
   endfunction

   task automatic check_int(input string name, input logic [31:0] instr, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s instr=%h got=%0d exp=%0d", name, instr, got, exp);
      end
   endtask

   task automatic check_out(input string name, input int idx, input out_t got, input out_t exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", name, idx, got, exp);
      end
   endtask

   function automatic void push(input out_t o, input logic mr, input logic bt, input logic chk);
      cyc_t c;
      c.exp = o; c.mr = mr; c.bt = bt; c.chk_alu = chk;
      mq.push_back(c);
   endfunction

   // Expected per-cycle outputs derived from the instruction class rules
   task automatic build(input logic [31:0] w, input int fw, input int mw, input logic taken);
      int   kind;
      int   aop_of[9] = '{0, 1, 2, 2, 3, 4, 5, 6, 7};
      logic [2:0] f3;
      out_t o, base;
      f3 = w[14:12];
      case (w[6:0])
         7'h33: kind = K_R;    7'h63: kind = K_BR;  7'h03: kind = K_LD;
         7'h23: kind = K_ST;   7'h13: kind = K_I;   7'h17: kind = K_AUI;
         7'h37: kind = K_LUI;  7'h6F: kind = K_JAL; 7'h67: kind = K_JALR;
         default: kind = K_ILL;
      endcase
      o = '0; o.mem_req = 1'b1;
      for (int i = 0; i < fw; i++) push(o, 1'b0, 1'($urandom), 1'b0);
      o.ir_we = 1'b1; o.pc_we = 1'b1;
      push(o, 1'b1, 1'($urandom), 1'b0);
      o = '0;
      push(o, 1'($urandom), 1'($urandom), 1'b0);
      if (kind == K_ILL) begin
         o.illegal = 1'b1;
         for (int i = 0; i < 5; i++) push(o, 1'($urandom), 1'($urandom), 1'b0);
      end else begin
         base = '0;
         base.aop  = 3'(aop_of[kind]);
         base.ains = {(kind == K_R || (kind == K_I && f3 == 3'd5)) ? w[30] : 1'b0, f3};
         o = base;
         o.a = (kind == K_AUI || kind == K_JAL);
         o.b = !(kind == K_R || kind == K_BR);
         if (kind == K_BR) begin
            o.pc_we = taken; o.pc_src = 2'b01;
         end else if (kind == K_JAL || kind == K_JALR) begin
            o.pc_we = 1'b1; o.pc_src = 2'b10;
         end
         push(o, 1'($urandom), taken, 1'b1);
         if (kind == K_LD || kind == K_ST) begin
            o = base; o.mem_req = 1'b1; o.mem_we = (kind == K_ST);
            for (int i = 0; i < mw; i++) push(o, 1'b0, 1'($urandom), 1'b1);
            push(o, 1'b1, 1'($urandom), 1'b1);
         end
         if (kind != K_BR && kind != K_ST) begin
            o = base; o.reg_we = 1'b1;
            o.wb_sel = (kind == K_LD) ? 2'b01 : (kind == K_JAL || kind == K_JALR) ? 2'b10 : 2'b00;
            push(o, 1'($urandom), 1'($urandom), 1'b1);
         end
      end
   endtask

   // Cycle-by-cycle comparison against the model; limit > 0 stops early
   task automatic run_model(input logic [31:0] w, input int fw, input int mw, input logic taken,
                            input int limit);
      int   n;
      out_t act, exp;
      mq.delete();
      build(w, fw, mw, taken);
      opcode = w[6:0]; funct3 = w[14:12]; funct7_5 = w[30];
      n = (limit > 0 && limit < mq.size()) ? limit : mq.size();
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         mem_ready    = mq[i].mr;
         branch_taken = mq[i].bt;
         #1;
         act = sample();
         exp = mq[i].exp;
         if (!mq[i].chk_alu) begin
            act.aop = '0; act.ains = '0; exp.aop = '0; exp.ains = '0;
         end
         check_out($sformatf("cycle_%h", w), i, act, exp);
      end
   endtask

   // Runs one instruction off DUT handshakes alone and checks summary figures
   task automatic run_tab(input tv_t tv);
      int phase = 0, wcnt = 0, lat = 0, rw = 0, wbs = 0, pcw = 0, stc = 0, cyc = 0;
      logic in_req = 1'b0, done = 1'b0;
      logic [6:0] last_alu = '0;
      opcode = tv.instr[6:0]; funct3 = tv.instr[14:12]; funct7_5 = tv.instr[30];
      while (!done && cyc < 40) begin
         @(negedge CLK);
         cyc++;
         if (mem_req && !in_req) begin
            phase++; wcnt = 0; in_req = 1'b1;
         end
         if (phase > tv.nreq) begin
            mem_ready = 1'b0;
            done = 1'b1;
         end else begin
            mem_ready    = mem_req ? (wcnt == ((phase == 1) ? tv.fw : tv.mw)) : 1'($urandom);
            branch_taken = tv.taken;
            #1;
            if (reg_we) begin rw++; wbs = int'(wb_sel); end
            if (pc_we) pcw++;
            if (mem_req && mem_we) stc++;
            last_alu = {alu_op, alu_instr};
            if (mem_req) begin
               if (mem_ready) in_req = 1'b0;
               else wcnt++;
            end
            lat++;
         end
      end
      #1;
      check_int("tab_done", tv.instr, int'(done), 1);
      check_int("tab_latency", tv.instr, lat, tv.lat);
      check_int("tab_reg_we_count", tv.instr, rw, tv.rw);
      check_int("tab_wb_sel", tv.instr, wbs, tv.wbs);
      check_int("tab_pc_we_count", tv.instr, pcw, tv.pcw);
      check_int("tab_store_cycles", tv.instr, stc, tv.stc);
      check_int("tab_alu_fields", tv.instr, int'(last_alu), int'(tv.alu));
   endtask

   tv_t        tab[15];
   logic [6:0] ops[9];
   logic [31:0] w;

   initial begin
      //             instr         fw mw tk nreq lat rw wbs pcw stc alu
      tab[0]  = '{32'h002081B3, 0, 0, 1'b0, 1, 4, 1, 0, 1, 0, 7'h00};
      tab[1]  = '{32'h4030D093, 0, 0, 1'b0, 1, 4, 1, 0, 1, 0, 7'h3D};
      tab[2]  = '{32'h40008093, 0, 0, 1'b0, 1, 4, 1, 0, 1, 0, 7'h30};
      tab[3]  = '{32'h00012083, 0, 3, 1'b0, 2, 8, 1, 1, 1, 0, 7'h22};
      tab[4]  = '{32'h00112023, 0, 0, 1'b0, 2, 4, 0, 0, 1, 1, 7'h22};
      tab[5]  = '{32'h00208463, 0, 0, 1'b1, 1, 3, 0, 0, 2, 0, 7'h10};
      tab[6]  = '{32'h00208463, 0, 0, 1'b0, 1, 3, 0, 0, 1, 0, 7'h10};
      tab[7]  = '{32'h000080E7, 0, 0, 1'b0, 1, 4, 1, 2, 2, 0, 7'h70};
      tab[8]  = '{32'h008000EF, 0, 0, 1'b0, 1, 4, 1, 2, 2, 0, 7'h60};
      tab[9]  = '{32'h123450B7, 0, 0, 1'b0, 1, 4, 1, 0, 1, 0, 7'h55};
      tab[10] = '{32'h00000097, 0, 0, 1'b0, 1, 4, 1, 0, 1, 0, 7'h40};
      tab[11] = '{32'h40208133, 2, 0, 1'b0, 1, 6, 1, 0, 1, 0, 7'h08};
      tab[12] = '{32'h4000E093, 0, 0, 1'b0, 1, 4, 1, 0, 1, 0, 7'h36};
      tab[13] = '{32'h40209463, 1, 0, 1'b0, 1, 4, 0, 0, 1, 0, 7'h11};
      tab[14] = '{32'h00112023, 1, 2, 1'b0, 2, 7, 0, 0, 1, 3, 7'h22};
      ops = '{7'h33, 7'h63, 7'h03, 7'h23, 7'h13, 7'h17, 7'h37, 7'h6F, 7'h67};

      RST_n = 1'b0; opcode = '0; funct3 = '0; funct7_5 = 1'b0;
      branch_taken = 1'b1; mem_ready = 1'b1;
      repeat (3) @(negedge CLK);
      #1 check_out("reset_state", 0, sample(), '0);
      @(negedge CLK);
      RST_n = 1'b1;

      foreach (tab[i]) run_tab(tab[i]);

      for (int n = 0; n < 150; n++) begin
         w = $urandom;
         w[6:0] = ops[$urandom_range(0, 8)];
         run_model(w, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom), 0);
      end

      // Load stalled in MEM, then reset lands mid-request
      run_model(32'h00012083, 0, 5, 1'b0, 5);
      #1 RST_n = 1'b0;
      #1 check_out("reset_mid_mem", 0, sample(), '0);
      @(negedge CLK);
      RST_n = 1'b1;

      run_model(32'h0000007F, 0, 0, 1'b0, 0);
      #1 RST_n = 1'b0;
      #1 check_out("reset_clears_illegal", 0, sample(), '0);
      @(negedge CLK);
      RST_n = 1'b1;

      run_model(32'h002081B3, 1, 0, 1'b0, 0);
      run_model(32'h00012083, 0, 3, 1'b0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
